// File: rtl/alu_sweep_sequencer.sv
// alu_sweep_sequencer
//
// Steps the shared barrel-shifter/ALU datapath through all 16 combinations
// of the 2-bit shift amounts for operands A and B, under one ALU operation
// latched at start. After each select change the result is allowed to
// settle, then sampled. The block accumulates the sum of the samples and
// tracks the largest sample together with the index where it first appeared.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-low reset
//   start      one-cycle request to begin a sweep (honoured only when idle)
//   abort      cancel a running sweep (ignored when idle)
//   step_en    pacing strobe; a new index is driven only when high
//   op_sel     ALU operation, latched at start
//   shift_mode shifter modes {B,A}, latched at start
//   alu_res    combinational ALU result for the current selects
//   sel_a      shift amount for shifter A  = {idx[2], idx[0]}
//   sel_b      shift amount for shifter B  = {idx[3], idx[1]}
//   alu_op     latched op_sel
//   bs_mode    latched shift_mode
//   idx        current sweep index 0..15
//   capture    one-cycle pulse in the cycle whose closing edge samples alu_res
//   busy       high from the cycle after an accepted start until completion
//   done       one-cycle pulse on normal completion
//   acc        sum of captured results
//   max_res    largest captured result
//   max_idx    index at which max_res was first captured
module alu_sweep_sequencer #(
    parameter int SETTLE = 2,
    parameter int RES_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             step_en,
    input  logic [1:0]       op_sel,
    input  logic [1:0]       shift_mode,
    input  logic [RES_W-1:0] alu_res,
    output logic [1:0]       sel_a,
    output logic [1:0]       sel_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       bs_mode,
    output logic [3:0]       idx,
    output logic             capture,
    output logic             busy,
    output logic             done,
    output logic [11:0]      acc,
    output logic [RES_W-1:0] max_res,
    output logic [3:0]       max_idx
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t           state_reg;
    logic [3:0]       cnt_reg;
    logic [3:0]       idx_reg;
    logic [1:0]       sel_a_reg;
    logic [1:0]       sel_b_reg;
    logic [1:0]       alu_op_reg;
    logic [1:0]       bs_mode_reg;
    logic             capture_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [11:0]      acc_reg;
    logic [RES_W-1:0] max_res_reg;
    logic [3:0]       max_idx_reg;

    logic [3:0]       idx_next;

    assign idx_next = idx_reg + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 4'd0;
            idx_reg     <= 4'd0;
            sel_a_reg   <= 2'd0;
            sel_b_reg   <= 2'd0;
            alu_op_reg  <= 2'd0;
            bs_mode_reg <= 2'd0;
            capture_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            acc_reg     <= 12'd0;
            max_res_reg <= '0;
            max_idx_reg <= 4'd0;
        end else begin
            // Pulses default low; they are raised only on the transition
            // into the state they mark, so they align with that state.
            capture_reg <= 1'b0;
            done_reg    <= 1'b0;

            if (state_reg == ST_IDLE) begin
                // start beats abort here simply because abort is not looked at.
                if (start) begin
                    alu_op_reg  <= op_sel;
                    bs_mode_reg <= shift_mode;
                    idx_reg     <= 4'd0;
                    sel_a_reg   <= 2'd0;
                    sel_b_reg   <= 2'd0;
                    acc_reg     <= 12'd0;
                    max_res_reg <= '0;
                    max_idx_reg <= 4'd0;
                    busy_reg    <= 1'b1;
                    state_reg   <= ST_DRIVE;
                end
            end else if (abort) begin
                // Abort takes priority over everything, including the
                // accumulate of a CAPTURE cycle; partial results are kept.
                busy_reg  <= 1'b0;
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_DRIVE: begin
                        if (step_en) begin
                            // Counter runs SETTLE-1 .. 0, giving SETTLE cycles.
                            cnt_reg   <= 4'(SETTLE - 1);
                            state_reg <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt_reg == 4'd0) begin
                            capture_reg <= 1'b1;
                            state_reg   <= ST_CAPTURE;
                        end else begin
                            cnt_reg <= cnt_reg - 4'd1;
                        end
                    end
                    ST_CAPTURE: begin
                        acc_reg <= acc_reg + 12'(alu_res);
                        // Strictly greater: ties keep the earliest index.
                        if (alu_res > max_res_reg) begin
                            max_res_reg <= alu_res;
                            max_idx_reg <= idx_reg;
                        end
                        if (idx_reg == 4'd15) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_DONE;
                        end else begin
                            idx_reg   <= idx_next;
                            // Interleaved mapping: A takes the even bits,
                            // B the odd bits of the index.
                            sel_a_reg <= {idx_next[2], idx_next[0]};
                            sel_b_reg <= {idx_next[3], idx_next[1]};
                            state_reg <= ST_DRIVE;
                        end
                    end
                    ST_DONE: begin
                        state_reg <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sel_a   = sel_a_reg;
    assign sel_b   = sel_b_reg;
    assign alu_op  = alu_op_reg;
    assign bs_mode = bs_mode_reg;
    assign idx     = idx_reg;
    assign capture = capture_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign acc     = acc_reg;
    assign max_res = max_res_reg;
    assign max_idx = max_idx_reg;

endmodule

// File: tb/tb_alu_sweep_sequencer.sv
// Testbench for alu_sweep_sequencer. The ALU is modelled in the bench as a
// function of the DUT's selects; expected sums/maxima are derived from the
// sweep order rule (idx 0..15, sel_a = even index bits, sel_b = odd bits).
module tb_alu_sweep_sequencer;

    localparam int SETTLE = 2;
    localparam int RES_W  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic             step_en;
    logic [1:0]       op_sel;
    logic [1:0]       shift_mode;
    logic [RES_W-1:0] alu_res;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;
    logic [1:0]       alu_op;
    logic [1:0]       bs_mode;
    logic [3:0]       idx;
    logic             capture;
    logic             busy;
    logic             done;
    logic [11:0]      acc;
    logic [RES_W-1:0] max_res;
    logic [3:0]       max_idx;

    always #5 clk = ~clk;

    alu_sweep_sequencer #(.SETTLE(SETTLE), .RES_W(RES_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .step_en    (step_en),
        .op_sel     (op_sel),
        .shift_mode (shift_mode),
        .alu_res    (alu_res),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .alu_op     (alu_op),
        .bs_mode    (bs_mode),
        .idx        (idx),
        .capture    (capture),
        .busy       (busy),
        .done       (done),
        .acc        (acc),
        .max_res    (max_res),
        .max_idx    (max_idx)
    );

    // ALU stand-in: 0 = {sel_b,sel_a,4'h0}, 1 = constant 0x55, 2 = random table
    int         alu_mode = 0;
    logic [7:0] rand_tab [16];

    always_comb begin
        case (alu_mode)
            0:       alu_res = {sel_b, sel_a, 4'h0};
            1:       alu_res = 8'h55;
            default: alu_res = rand_tab[{sel_b, sel_a}];
        endcase
    end

    int tests_run    = 0;
    int tests_failed = 0;

    // Observations gathered by collect()
    int         cap_idx_q [$];
    logic [1:0] cap_sa_q  [$];
    logic [1:0] cap_sb_q  [$];
    int         cap_gap_q [$];
    int         done_cyc;
    int         done_cnt;
    int         op_err_cnt;
    bit         timed_out;
    logic       busy_at_done;
    logic       busy_first;
    logic       post_busy;
    logic       post_capture;
    logic       post_done;

    // Reference: ALU value seen at sweep position i, from the mapping rule.
    function automatic logic [7:0] model_res(input int i);
        logic [1:0] sa;
        logic [1:0] sb;
        sa = 2'((i >> 1) & 2) | 2'(i & 1);         // bits {i2,i0}
        sb = 2'((i >> 2) & 2) | 2'((i >> 1) & 1);  // bits {i3,i1}
        case (alu_mode)
            0:       return {sb, sa, 4'h0};
            1:       return 8'h55;
            default: return rand_tab[{sb, sa}];
        endcase
    endfunction

    function automatic logic [1:0] model_sa(input int i);
        return 2'((i >> 1) & 2) | 2'(i & 1);
    endfunction

    function automatic logic [1:0] model_sb(input int i);
        return 2'((i >> 2) & 2) | 2'((i >> 1) & 1);
    endfunction

    task automatic model_sweep(input int n, output int sum, output int mx, output int mxi);
        sum = 0; mx = 0; mxi = 0;
        for (int i = 0; i < n; i++) begin
            sum += int'(model_res(i));
            if (int'(model_res(i)) > mx) begin
                mx  = int'(model_res(i));
                mxi = i;
            end
        end
    endtask

    task automatic do_start(input logic [1:0] op, input logic [1:0] mode);
        @(negedge clk);
        op_sel     = op;
        shift_mode = mode;
        start      = 1'b1;
    endtask

    // Runs the sweep cycle by cycle (cycle 1 = first cycle after the start edge).
    task automatic collect(input int budget, input int pace, input int abort_at,
                           input bit latch_test, input logic [1:0] exp_op);
        int  cyc;
        int  last_step;
        bit  aborted;
        cyc = 0; last_step = -100; aborted = 0;
        cap_idx_q.delete(); cap_sa_q.delete(); cap_sb_q.delete(); cap_gap_q.delete();
        done_cyc = -1; done_cnt = 0; op_err_cnt = 0; timed_out = 1;
        busy_at_done = 1'bx; busy_first = 1'bx;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                busy_first = busy;
                abort      = 1'b0;
                if (latch_test) begin
                    op_sel     = 2'd1;
                    shift_mode = ~shift_mode;
                end
            end
            start = latch_test && (cyc == 20);
            if (busy && alu_op !== exp_op) op_err_cnt++;
            if (aborted) begin
                post_busy = busy; post_capture = capture; post_done = done;
                timed_out = 0;
                break;
            end
            if (capture) begin
                cap_idx_q.push_back(int'(idx));
                cap_sa_q.push_back(sel_a);
                cap_sb_q.push_back(sel_b);
                cap_gap_q.push_back(cyc - last_step);
            end
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
                timed_out    = 0;
                break;
            end
            if (abort_at > 0 && cap_idx_q.size() == abort_at) begin
                abort   = 1'b1;
                aborted = 1;
            end
            step_en = (pace <= 1) ? 1'b1 : ((cyc % pace) == 0);
            if (step_en) last_step = cyc;
        end
        abort   = 1'b0;
        step_en = 1'b1;
        start   = 1'b0;
        $display("[TB] sweep: captures=%0d done_cyc=%0d acc=%03h max=%02h@%0d",
                 cap_idx_q.size(), done_cyc, acc, max_res, max_idx);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (busy !== 1'b0 || done !== 1'b0 || capture !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ctrl: busy=%b done=%b capture=%b expected 000", busy, done, capture); end
        tests_run++; if (acc !== 12'd0 || max_res !== 8'd0 || max_idx !== 4'd0 || idx !== 4'd0) begin
            tests_failed++; $display("FAIL reset_data: acc=%h max=%h mi=%h idx=%h expected 0", acc, max_res, max_idx, idx); end
        tests_run++; if (sel_a !== 2'd0 || sel_b !== 2'd0 || alu_op !== 2'd0 || bs_mode !== 2'd0) begin
            tests_failed++; $display("FAIL reset_sel: sa=%h sb=%h op=%h bm=%h expected 0", sel_a, sel_b, alu_op, bs_mode); end
        rst = 1'b1;
        // Mid-sweep reset
        alu_mode = 0;
        do_start(2'd3, 2'd3);
        repeat (20) begin
            @(negedge clk);
            start = 1'b0;
        end
        tests_run++; if (busy !== 1'b1 || acc === 12'd0) begin
            tests_failed++; $display("FAIL midsweep_pre: busy=%b acc=%h expected busy=1 acc!=0", busy, acc); end
        rst = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0 || capture !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL async_reset_ctrl: busy=%b capture=%b done=%b expected 000", busy, capture, done); end
        tests_run++; if (acc !== 12'd0 || idx !== 4'd0 || alu_op !== 2'd0 || bs_mode !== 2'd0) begin
            tests_failed++; $display("FAIL async_reset_data: acc=%h idx=%h op=%h bm=%h expected 0", acc, idx, alu_op, bs_mode); end
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        tests_run++; if (busy !== 1'b0 || idx !== 4'd0 || capture !== 1'b0) begin
            tests_failed++; $display("FAIL reset_idle: busy=%b idx=%0d capture=%b expected idle", busy, idx, capture); end
    endtask

    task automatic test_full_sweep();
        int sum, mx, mxi;
        alu_mode = 0;
        do_start(2'd3, 2'd2);
        collect(400, 1, 0, 0, 2'd3);
        model_sweep(16, sum, mx, mxi);
        tests_run++; if (timed_out) begin
            tests_failed++; $display("FAIL full_timeout: no done within budget, expected done"); end
        tests_run++; if (busy_first !== 1'b1) begin
            tests_failed++; $display("FAIL full_busy_rise: busy=%b expected 1", busy_first); end
        tests_run++; if (cap_idx_q.size() != 16) begin
            tests_failed++; $display("FAIL full_captures: got %0d expected 16", cap_idx_q.size()); end
        for (int i = 0; i < cap_idx_q.size() && i < 16; i++) begin
            tests_run++; if (cap_idx_q[i] != i || cap_sa_q[i] !== model_sa(i) || cap_sb_q[i] !== model_sb(i)) begin
                tests_failed++; $display("FAIL full_order[%0d]: idx=%0d sa=%0d sb=%0d expected idx=%0d sa=%0d sb=%0d",
                    i, cap_idx_q[i], cap_sa_q[i], cap_sb_q[i], i, model_sa(i), model_sb(i)); end
        end
        tests_run++; if (acc !== 12'h780 || int'(acc) != sum) begin
            tests_failed++; $display("FAIL full_acc: got %h expected 780", acc); end
        tests_run++; if (max_res !== 8'hF0 || max_idx !== 4'd15) begin
            tests_failed++; $display("FAIL full_max: got %h@%0d expected f0@15", max_res, max_idx); end
        tests_run++; if (done_cyc != 16 * (SETTLE + 2) + 1 || busy_at_done !== 1'b0) begin
            tests_failed++; $display("FAIL full_done_timing: done_cyc=%0d busy=%b expected %0d busy=0",
                done_cyc, busy_at_done, 16 * (SETTLE + 2) + 1); end
        tests_run++; if (op_err_cnt != 0 || bs_mode !== 2'd2) begin
            tests_failed++; $display("FAIL full_latch: op_err=%0d bm=%0d expected 0 and 2", op_err_cnt, bs_mode); end
        @(negedge clk);
        tests_run++; if (done !== 1'b0 || acc !== 12'h780) begin
            tests_failed++; $display("FAIL full_hold: done=%b acc=%h expected done=0 acc=780", done, acc); end
    endtask

    task automatic test_ties();
        alu_mode = 1;
        do_start(2'd0, 2'd0);
        collect(400, 1, 0, 0, 2'd0);
        tests_run++; if (timed_out || acc !== 12'h550) begin
            tests_failed++; $display("FAIL ties_acc: got %h timeout=%0d expected 550", acc, timed_out); end
        tests_run++; if (max_res !== 8'h55 || max_idx !== 4'd0) begin
            tests_failed++; $display("FAIL ties_max: got %h@%0d expected 55@0", max_res, max_idx); end
    endtask

    task automatic test_random();
        int sum, mx, mxi;
        logic [1:0] op;
        for (int r = 0; r < 3; r++) begin
            alu_mode = 2;
            for (int k = 0; k < 16; k++) rand_tab[k] = 8'($urandom_range(0, 255));
            op = 2'($urandom_range(0, 3));
            do_start(op, 2'($urandom_range(0, 3)));
            collect(400, 1, 0, 0, op);
            model_sweep(16, sum, mx, mxi);
            tests_run++; if (timed_out || int'(acc) != sum) begin
                tests_failed++; $display("FAIL random_acc[%0d]: got %h expected %h", r, acc, sum); end
            tests_run++; if (int'(max_res) != mx || int'(max_idx) != mxi) begin
                tests_failed++; $display("FAIL random_max[%0d]: got %h@%0d expected %h@%0d", r, max_res, max_idx, mx, mxi); end
        end
    endtask

    task automatic test_pacing();
        int sum, mx, mxi;
        int bad;
        alu_mode = 2;
        for (int k = 0; k < 16; k++) rand_tab[k] = 8'($urandom_range(0, 255));
        do_start(2'd1, 2'd1);
        step_en = 1'b0;
        collect(600, 10, 0, 0, 2'd1);
        model_sweep(16, sum, mx, mxi);
        tests_run++; if (timed_out || cap_idx_q.size() != 16) begin
            tests_failed++; $display("FAIL pacing_captures: got %0d timeout=%0d expected 16", cap_idx_q.size(), timed_out); end
        bad = 0;
        for (int i = 0; i < cap_gap_q.size(); i++)
            if (cap_gap_q[i] != SETTLE + 1 || cap_idx_q[i] != i) bad++;
        tests_run++; if (bad != 0) begin
            tests_failed++; $display("FAIL pacing_gap: %0d captures off, expected each SETTLE+1=%0d after step_en", bad, SETTLE + 1); end
        tests_run++; if (int'(acc) != sum) begin
            tests_failed++; $display("FAIL pacing_acc: got %h expected %h", acc, sum); end
    endtask

    task automatic test_abort();
        int sum, mx, mxi;
        alu_mode = 2;
        for (int k = 0; k < 16; k++) rand_tab[k] = 8'($urandom_range(1, 255));
        do_start(2'd2, 2'd0);
        collect(400, 1, 5, 0, 2'd2);
        model_sweep(4, sum, mx, mxi);
        tests_run++; if (timed_out || post_busy !== 1'b0 || post_capture !== 1'b0) begin
            tests_failed++; $display("FAIL abort_stop: busy=%b capture=%b timeout=%0d expected 0 0", post_busy, post_capture, timed_out); end
        tests_run++; if (done_cnt != 0 || post_done !== 1'b0) begin
            tests_failed++; $display("FAIL abort_done: done pulses=%0d done=%b expected none", done_cnt, post_done); end
        tests_run++; if (int'(acc) != sum || int'(max_res) != mx || int'(max_idx) != mxi) begin
            tests_failed++; $display("FAIL abort_partial: acc=%h max=%h@%0d expected %h %h@%0d", acc, max_res, max_idx, sum, mx, mxi); end
        repeat (3) @(negedge clk);
        tests_run++; if (busy !== 1'b0 || int'(acc) != sum) begin
            tests_failed++; $display("FAIL abort_hold: busy=%b acc=%h expected 0 %h", busy, acc, sum); end
    endtask

    task automatic test_latching();
        alu_mode = 0;
        do_start(2'd2, 2'd1);
        collect(400, 1, 0, 1, 2'd2);
        tests_run++; if (timed_out || op_err_cnt != 0 || alu_op !== 2'd2 || bs_mode !== 2'd1) begin
            tests_failed++; $display("FAIL latch_op: errs=%0d op=%0d bm=%0d expected op=2 bm=1", op_err_cnt, alu_op, bs_mode); end
        tests_run++; if (cap_idx_q.size() != 16 || done_cyc != 16 * (SETTLE + 2) + 1) begin
            tests_failed++; $display("FAIL latch_restart: captures=%0d done_cyc=%0d expected 16 and %0d",
                cap_idx_q.size(), done_cyc, 16 * (SETTLE + 2) + 1); end
        tests_run++; if (acc !== 12'h780) begin
            tests_failed++; $display("FAIL latch_acc: got %h expected 780", acc); end
    endtask

    task automatic test_back_to_back();
        alu_mode = 0;
        do_start(2'd1, 2'd0);
        collect(400, 1, 0, 0, 2'd1);
        // DUT is in DONE this cycle: start must be ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++; if (busy !== 1'b0 || acc !== 12'h780) begin
            tests_failed++; $display("FAIL b2b_done_start: busy=%b acc=%h expected busy=0 acc=780", busy, acc); end
        // start and abort together in IDLE: start wins, previous results cleared.
        alu_mode = 1;
        do_start(2'd0, 2'd3);
        abort = 1'b1;
        collect(400, 1, 0, 0, 2'd0);
        tests_run++; if (busy_first !== 1'b1 || timed_out) begin
            tests_failed++; $display("FAIL b2b_start_abort: busy=%b timeout=%0d expected busy=1", busy_first, timed_out); end
        tests_run++; if (acc !== 12'h550 || max_res !== 8'h55 || max_idx !== 4'd0) begin
            tests_failed++; $display("FAIL b2b_result: acc=%h max=%h@%0d expected 550 55@0", acc, max_res, max_idx); end
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; step_en = 1'b1;
        op_sel = 2'd0; shift_mode = 2'd0;
        for (int k = 0; k < 16; k++) rand_tab[k] = 8'd0;
        test_reset();
        test_full_sweep();
        test_ties();
        test_random();
        test_pacing();
        test_abort();
        test_latching();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_sweep_sequencer.md
# alu_sweep_sequencer

Sequencer that drives the shared barrel-shifter/ALU datapath through a full sweep of all 16 shift-amount combinations for operands A and B under one latched ALU operation. It sits between the operand counters/shifters/ALU and the display logic. It replaces free-running select generation with a start/busy/done-controlled run. Each ALU result is captured after a settle window, and the block accumulates the sum and the maximum result with its index for display.

## Interface
Parameters:
- SETTLE, 2, cycles from select change to result capture (legal 1..15)
- RES_W, 8, ALU result width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a sweep (honoured only in IDLE)
- abort  in  1  cancel the running sweep
- step_en  in  1  pacing strobe from the clock divider; DRIVE advances only when high
- op_sel  in  2  ALU operation, latched at start
- shift_mode  in  2  per-operand shifter mode {B,A}, latched at start
- alu_res  in  RES_W  combinational ALU result for the current selects
- sel_a  out  2  shift amount to barrel shifter A
- sel_b  out  2  shift amount to barrel shifter B
- alu_op  out  2  ALU operation (latched op_sel)
- bs_mode  out  2  shifter modes (latched shift_mode)
- idx  out  4  current sweep index 0..15
- capture  out  1  one-cycle pulse when alu_res is sampled
- busy  out  1  high from the cycle after accepted start until DONE
- done  out  1  one-cycle pulse on normal completion
- acc  out  12  sum of the 16 captured results
- max_res  out  RES_W  largest captured result
- max_idx  out  4  idx at which max_res was first seen

## Operation
- States: IDLE, DRIVE, SETTLE, CAPTURE, DONE. All outputs are registered.
- Select mapping (interleaved): sel_a = {idx[2], idx[0]}, sel_b = {idx[3], idx[1]}.
- IDLE:
  - start=1 latches op_sel/shift_mode, clears idx, acc, max_res and max_idx, then enters DRIVE.
  - abort is ignored.
- DRIVE: with step_en=1, loads the settle counter with SETTLE-1 and enters SETTLE. Otherwise it holds.
- SETTLE: decrements the counter. At 0 it enters CAPTURE.
- CAPTURE:
  - capture=1 for this cycle.
  - acc += alu_res, zero-extended to 12 bits. Maximum is 16×255 = 4080, so no overflow.
  - If alu_res > max_res (strictly greater), max_res and max_idx are updated. Ties keep the earlier index. At idx=0 the capture always loads, because max_res was cleared to 0; this applies only when alu_res > 0.
  - If idx=15, enters DONE. Otherwise idx increments and the FSM enters DRIVE.
- DONE: done=1 for one cycle, busy drops, then returns to IDLE. acc, max_res, max_idx, alu_op and bs_mode hold until the next accepted start.
- abort in any non-IDLE state:
  - Goes to IDLE on the next edge with no done pulse and no capture.
  - acc and max keep their partial values.
  - abort wins over a simultaneous CAPTURE: that sample is discarded.
- start while busy is ignored. start and abort together in IDLE: start wins.
- Reset values: state IDLE, idx=0, sel_a=sel_b=0, alu_op=0, bs_mode=0, capture=0, busy=0, done=0, acc=0, max_res=0, max_idx=0.
- Reset mid-sweep forces all of the above immediately (asynchronous reset).

## Timing
- start sampled at edge t: busy=1, idx=0 and selects valid from t+1.
- Per index: 1 DRIVE cycle (plus wait for step_en) + SETTLE cycles + 1 CAPTURE cycle.
- With step_en tied high, a sweep takes 16×(SETTLE+2) cycles from busy rising to DONE.
  - At SETTLE=2 this is 64 cycles, and done pulses at cycle t+65.
- alu_res is sampled on the clock edge that ends CAPTURE. The selects have been stable for at least SETTLE+1 cycles at that point.
- idx and the selects change on the edge leaving CAPTURE.
- busy falls in the same cycle that done rises.

## Test plan
- Reset: hold rst=0 mid-sweep with busy=1 → busy, capture and done are 0 immediately, acc=0 and idx=0. After release, the FSM stays idle until start.
- Full sweep, ALU model alu_res={sel_b,sel_a,4'h0}, step_en=1, SETTLE=2 → 16 capture pulses with idx 0..15 in order, and sel_a/sel_b follow the interleaved mapping. Final values:
  - acc = 16 × (the average of the 16 alu_res values) = 0x780.
  - max_res = 0xF0, max_idx = 15.
  - done pulses at t+65.
- Ties: alu_res constant 0x55 → max_res=0x55, max_idx=0, acc=0x550.
- Pacing: step_en pulses every 10 cycles → each index stays in DRIVE until step_en, then SETTLE+1 further cycles. Exactly 16 captures occur.
- Abort: abort asserted in the same cycle as the 5th CAPTURE → no capture counted for idx 4, acc holds the sum of idx 0..3, no done pulse, busy=0 next cycle.
- Latching: start with op_sel=2, then change op_sel to 1 mid-sweep → alu_op stays 2 for the whole sweep. start pulsed while busy → no restart, idx continues.
